// File: rtl/dcache_pkg.sv
// Shared types and address-field constants for the direct-mapped,
// write-through data cache controller.
package dcache_pkg;

    localparam int ADDR_W = 32;  // CPU byte-address width
    localparam int WORD_W = 32;  // one data word per line
    localparam int OFF_W  = 2;   // byte offset within a word, ignored

    // Controller FSM states; IDLE is all-zero so it reads as 0 during reset.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    // Tag width left over once the index and byte offset are removed.
    function automatic int tag_width(input int idx_w);
        return ADDR_W - idx_w - OFF_W;
    endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational
// read port, one synchronous write port, valid bits cleared synchronously
// while rst is high. A write always marks the line valid.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [WORD_W-1:0] data_q [LINES];
    logic [WORD_W-1:0] data_d [LINES];

    // Read port: straight lookup of the addressed line.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_data  = data_q[rd_idx];
    end

    // Next contents: the written line takes the new tag/data and becomes valid.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    // Valid bits: synchronous clear under reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays need no reset; an invalid line is never a hit.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Load hits complete in the request cycle; load misses and all stores
// wait MEM_LAT cycles on the memory side.
// Optional feature: define DCACHE_STATS_EN to add saturating hit/miss
// counters on stat_hits / stat_misses.
//
// Handshake: the CPU holds cpu_req/cpu_we/cpu_addr/cpu_wdata stable until
// the cycle in which cpu_ready is high; that cycle completes the access and
// a new request may be presented in the very next cycle.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES   = 16,  // power of two, 4..256
    parameter int MEM_LAT = 2    // at least 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
`endif
    output state_e            dbg_state,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = tag_width(IDX_W);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr_bits;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;
    logic              hit;

    logic              ram_we;
    logic [WORD_W-1:0] ram_wdata;
    logic              hit_evt;
    logic              miss_evt;

    assign addr_idx         = cpu_addr[IDX_W+1:OFF_W];
    assign addr_tag         = cpu_addr[ADDR_W-1:IDX_W+OFF_W];
    assign word_addr        = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^cpu_addr[OFF_W-1:0];
    assign hit              = rd_valid && (rd_tag == addr_tag);
    assign dbg_state        = state_q;

    dcache_line_ram #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_line_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (addr_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (ram_we),
        .wr_idx   (addr_idx),
        .wr_tag   (addr_tag),
        .wr_data  (ram_wdata)
    );

    // State register and latency counter; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: misses and every store wait out the memory latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req && cpu_we) begin
                    state_d = WR_THRU;
                    cnt_d   = CNT_INIT;
                end else if (cpu_req && !hit) begin
                    state_d = RD_MISS;
                    cnt_d   = CNT_INIT;
                end
            end
            RD_MISS, WR_THRU: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: CPU and memory drive, line writes, and completion events.
    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req && !cpu_we && hit) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = rd_data;
                    hit_evt   = 1'b1;
                end
            end
            RD_MISS: begin
                mem_rd   = 1'b1;
                mem_addr = word_addr;
                if (cnt_q == '0) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = mem_rdata;
                    ram_we    = 1'b1;
                    ram_wdata = mem_rdata;
                    miss_evt  = 1'b1;
                end
            end
            WR_THRU: begin
                mem_addr  = word_addr;
                mem_wdata = cpu_wdata;
                // The counter is still at its load value only in the first cycle.
                mem_wr    = (cnt_q == CNT_INIT);
                if (cnt_q == '0) begin
                    cpu_ready = 1'b1;
                    ram_we    = hit;
                    ram_wdata = cpu_wdata;
                end
            end
            default: begin
                cpu_ready = 1'b0;
            end
        endcase
        // A dropped request never completes; reset silences everything at once.
        if (!cpu_req || rst) begin
            cpu_ready = 1'b0;
            cpu_rdata = '0;
            hit_evt   = 1'b0;
            miss_evt  = 1'b0;
        end
        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wr    = 1'b0;
            mem_rd    = 1'b0;
            ram_we    = 1'b0;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (hit_evt && (stat_hits_q != '1)) begin
            stat_hits_d = stat_hits_q + 32'd1;
        end
        if (miss_evt && (stat_misses_q != '1)) begin
            stat_misses_d = stat_misses_q + 32'd1;
        end
    end

    // Statistics registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    logic unused_evts;
    assign unused_evts = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: reference cache model plus a memory
// array, expected load data queued at issue and popped at cpu_ready.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int LINES   = 16;
    localparam int MEM_LAT = 2;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    state_e      dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    // memory model (4 KiB) and reference cache
    logic [31:0] mem_a [1024];
    logic        ref_valid [LINES];
    logic [25:0] ref_tag   [LINES];
    logic [31:0] ref_data  [LINES];
    logic [31:0] exp_q [$];
    int          exp_hits;
    int          exp_misses;

    int n_vec;
    int n_fail;

    dcache_ctrl #(
        .LINES   (LINES),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
`ifdef DCACHE_STATS_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .dbg_state   (dbg_state),
        .mem_rdata   (mem_rdata)
    );

    // clock / memory read path
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_rd ? mem_a[mem_addr[11:2]] : 32'h0;

    // ---------------- driver with inline checks ----------------
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int          idx;
        logic [25:0] tag;
        logic        hit;
        int          exp_lat;
        int          lat;
        int          cyc;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] want;
        idx = int'(addr[5:2]);
        tag = addr[31:6];
        hit = ref_valid[idx] && (ref_tag[idx] == tag);
        exp_lat = (we || !hit) ? MEM_LAT : 0;
        if (!we) exp_q.push_back(hit ? ref_data[idx] : mem_a[addr[11:2]]);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        lat = -1; cyc = 0; rd_cyc = 0; wr_cyc = 0;
        while (lat < 0 && cyc < 20) begin
            @(negedge clk);
            n_vec++;
            if (mem_rd && mem_wr) begin
                n_fail++;
                $display("FAIL strobe_excl: mem_rd=%0b mem_wr=%0b both high, required not both", mem_rd, mem_wr);
            end
            if (mem_rd || mem_wr) begin
                n_vec++;
                if (mem_addr !== {addr[31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL mem_addr: got %h expected %h", mem_addr, {addr[31:2], 2'b00});
                end
            end
            if (mem_rd) rd_cyc++;
            if (mem_wr) begin
                wr_cyc++;
                n_vec++;
                if (mem_wdata !== wdata) begin
                    n_fail++;
                    $display("FAIL mem_wdata: got %h expected %h", mem_wdata, wdata);
                end
            end
            if (cpu_ready) begin
                lat = cyc;
                want = we ? 32'h0 : exp_q.pop_front();
            end else begin
                want = 32'h0;
            end
            n_vec++;
            if (cpu_rdata !== want) begin
                n_fail++;
                $display("FAIL cpu_rdata @%h: got %h expected %h", addr, cpu_rdata, want);
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency %s @%h: got %0d expected %0d (-1 = timeout)", we ? "st" : "ld", addr, lat, exp_lat);
            if (lat < 0 && !we) void'(exp_q.pop_front());
        end
        n_vec++;
        if (rd_cyc != ((!we && !hit) ? MEM_LAT : 0)) begin
            n_fail++;
            $display("FAIL mem_rd_cycles @%h: got %0d expected %0d", addr, rd_cyc, (!we && !hit) ? MEM_LAT : 0);
        end
        n_vec++;
        if (wr_cyc != (we ? 1 : 0)) begin
            n_fail++;
            $display("FAIL mem_wr_cycles @%h: got %0d expected %0d", addr, wr_cyc, we ? 1 : 0);
        end
        // reference model update
        if (we) begin
            mem_a[addr[11:2]] = wdata;
            if (hit) ref_data[idx] = wdata;
        end else if (hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            ref_data[idx]  = mem_a[addr[11:2]];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({cpu_ready, mem_rd, mem_wr} !== 3'b000 || cpu_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b rd=%0b wr=%0b rdata=%h addr=%h wdata=%h state=%0d, required all 0",
                     cpu_ready, mem_rd, mem_wr, cpu_rdata, mem_addr, mem_wdata, dbg_state);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h40;
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if ({cpu_ready, mem_rd, mem_wr} !== 3'b000 || dbg_state !== IDLE) begin
                n_fail++;
                $display("FAIL idle: ready=%0b rd=%0b wr=%0b state=%0d, required 0/0/0/IDLE",
                         cpu_ready, mem_rd, mem_wr, dbg_state);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_read_miss_hit();
        access(1'b0, 32'h40, 32'h0);  // cold miss
        access(1'b0, 32'h40, 32'h0);  // hit, zero latency
        access(1'b0, 32'h43, 32'h0);  // byte offset ignored, still a hit
    endtask

    task automatic test_store_hit();
        access(1'b1, 32'h40, 32'hDEADBEEF);
        access(1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_store_miss();
        access(1'b1, 32'h80, 32'h12345678);  // same index as 0x40, no allocate
        access(1'b0, 32'h40, 32'h0);         // still DEADBEEF hit
        access(1'b0, 32'h80, 32'h0);         // misses, sees stored word
    endtask

    task automatic test_conflict();
        access(1'b0, 32'h00, 32'h0);
        access(1'b0, 32'h40, 32'h0);
        access(1'b0, 32'h00, 32'h0);
    endtask

    task automatic test_reset_mid_access();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104; cpu_wdata = 32'h0;
        @(posedge clk); #1;                // first RD_MISS cycle
        @(posedge clk); #1;                // second RD_MISS cycle
        rst = 1'b1;
        #1;
        n_vec++;
        if ({cpu_ready, mem_rd, mem_wr} !== 3'b000 || cpu_rdata !== 32'h0 ||
            mem_addr !== 32'h0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%0b rd=%0b wr=%0b rdata=%h addr=%h state=%0d, required all 0",
                     cpu_ready, mem_rd, mem_wr, cpu_rdata, mem_addr, dbg_state);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        access(1'b0, 32'h104, 32'h0);      // must miss again
        access(1'b0, 32'h40, 32'h0);       // all lines invalid after reset
    endtask

    task automatic test_back_to_back();
        logic        we;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            we   = ($urandom_range(0, 3) == 0);
            addr = 32'($urandom_range(0, 63)) << 2;
            access(we, addr, $urandom);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        n_vec++;
        if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
            n_fail++;
            $display("FAIL stats: hits=%0d misses=%0d, required %0d/%0d",
                     stat_hits, stat_misses, exp_hits, exp_misses);
        end
    endtask
`endif

    initial begin
        n_vec = 0; n_fail = 0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 32'hC0DE0000 + 32'(i);
        model_reset();
        test_reset();
        test_idle();
        test_read_miss_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_access();
        test_back_to_back();
        test_idle();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines; power of two, 4..256.
REQ-002 Parameter MEM_LAT, default 2, memory access latency in cycles; must be at least 1.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cpu_req  in  1  CPU access request, held until cpu_ready.
REQ-006 cpu_we  in  1  1 = store, 0 = load; held with cpu_req.
REQ-007 cpu_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  in  32  store data.
REQ-009 cpu_rdata  out  32  load data, valid when cpu_ready is high and cpu_we is low.
REQ-010 cpu_ready  out  1  access completes this cycle; the CPU stalls while cpu_req is high and cpu_ready is low.
REQ-011 mem_addr  out  32  word-aligned memory address, with bits [1:0] = 0.
REQ-012 mem_wdata  out  32  memory write data.
REQ-013 mem_wr  out  1  memory write strobe.
REQ-014 mem_rd  out  1  memory read enable.
REQ-015 mem_rdata  in  32  memory read data; combinational from mem_addr while mem_rd is high.

Function
REQ-016 Address split SHALL be: index = cpu_addr[IDX_W+1:2], tag = cpu_addr[31:IDX_W+2], with IDX_W = log2(LINES).
REQ-017 Each line SHALL hold a valid bit, a tag and one 32-bit data word.
REQ-018 The FSM SHALL have three states: IDLE, RD_MISS, WR_THRU.
REQ-019 IDLE, load hit (valid and tag match): cpu_ready=1 and cpu_rdata=line data in the same cycle (0-cycle latency); stay in IDLE.
REQ-020 IDLE, load miss: go to RD_MISS and load the latency counter with MEM_LAT-1; cpu_ready=0.
REQ-021 RD_MISS: hold mem_rd=1 and mem_addr={cpu_addr[31:2],2'b00}.
REQ-022 RD_MISS, counter at 0: cpu_ready=1, cpu_rdata=mem_rdata; write the line (valid=1, tag, data); return to IDLE. Otherwise decrement the counter.
REQ-023 IDLE, any store (write-through, no-write-allocate): go to WR_THRU and load the counter with MEM_LAT-1.
REQ-024 WR_THRU: mem_wr=1 only in the first WR_THRU cycle; mem_addr and mem_wdata held for the whole state.
REQ-025 WR_THRU, counter at 0: cpu_ready=1; if the line hits, update its data word; a missing line is not allocated; return to IDLE.
REQ-026 mem_rd and mem_wr SHALL never be high in the same cycle; both SHALL be 0 in IDLE.
REQ-027 cpu_ready SHALL be 0 whenever cpu_req is 0.
REQ-028 The cycle after cpu_ready SHALL accept a new request with no idle gap.
REQ-029 cpu_rdata SHALL be 0 when cpu_ready is 0 or cpu_we is 1.

Reset
REQ-030 rst SHALL clear all valid bits, set the state to IDLE and clear the counter.
REQ-031 During reset, all outputs SHALL be 0.
REQ-032 rst asserted mid-access SHALL abandon the access: no line update and no further memory strobe; the CPU re-issues the request.

Configuration
REQ-033 With macro DCACHE_STATS_EN defined, the block SHALL add outputs stat_hits[31:0] and stat_misses[31:0], with these rules:
- stat_hits increments on each load hit completion;
- stat_misses increments on each RD_MISS completion;
- both saturate at 0xFFFFFFFF and are cleared by rst.
REQ-034 Without DCACHE_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-035 The shared package dcache_pkg SHALL hold the FSM state typedef (IDLE, RD_MISS, WR_THRU) and the address-field width constants.
REQ-036 The valid/tag/data storage SHALL be a sub-module dcache_line_ram, with:
- one combinational read port;
- one synchronous write port;
- a synchronous valid-clear on rst.
REQ-037 The FSM, the latency counter and the memory-side drive SHALL remain in dcache_ctrl.

Verification
REQ-038 Load to 0x40 after reset -> RD_MISS:
- mem_rd=1 and mem_addr=0x40 for 2 cycles;
- then cpu_ready=1 with cpu_rdata=memory word 0x40.
REQ-039 Repeat load of 0x40 -> cpu_ready=1 in the request cycle, with no mem_rd.
REQ-040 Store 0xDEADBEEF to 0x40 (line valid) -> mem_wr=1 for exactly one cycle; cpu_ready after 2 cycles; next load of 0x40 hits and returns 0xDEADBEEF.
REQ-041 Store to 0x80 (miss, same index as 0x40 at LINES=16) -> memory is written; the 0x40 line is untouched; a load of 0x80 then misses.
REQ-042 Load 0x00 then load 0x40 (index conflict) -> the second load misses and evicts; a reload of 0x00 misses again.
REQ-043 rst pulsed during the second RD_MISS cycle -> outputs are 0 immediately; a later load of the same address misses.
